// File: rtl/powlib_sfifo_sync.sv
// rtl/powlib_sfifo_sync.sv - single-clock first-word-fall-through FIFO with nearly-full flag and synchronized flush
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset (also clears the flush synchronizer)
//   flushreq  asynchronous flush request, synchronized through SS flops
//   wrdata    write data (W bits)
//   wrvld     write data valid
//   wrrdy     FIFO can accept a word
//   wrnf      nearly full: occupancy >= D-NFS-1
//   rddata    head-of-FIFO data (combinational RAM read)
//   rdvld     head data valid (FIFO not empty)
//   rdrdy     consumer ready

module powlib_sfifo_sync #(
    parameter int W   = 16,
    parameter int D   = 8,
    parameter int NFS = 0,
    parameter int SS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flushreq,
    input  logic [W-1:0] wrdata,
    input  logic         wrvld,
    output logic         wrrdy,
    output logic         wrnf,
    output logic [W-1:0] rddata,
    output logic         rdvld,
    input  logic         rdrdy
);

    localparam int WPTR = (D > 1) ? $clog2(D) : 1;
    localparam int NFT  = D - NFS - 1;
    localparam logic [WPTR-1:0] PTR_LAST = WPTR'(D - 1);
    localparam logic [WPTR-1:0] NFT_V    = WPTR'(NFT);

    generate
        if ((NFS + 1 > D) || (D < 2) || (SS < 2)) begin : g_bad_params
            $fatal(1, "%m: illegal parameters W=%0d D=%0d NFS=%0d SS=%0d", W, D, NFS, SS);
        end
    endgenerate

    // Pointers wrap at D rather than 2^WPTR so non-power-of-2 depths work.
    function automatic logic [WPTR-1:0] ptr_next(input logic [WPTR-1:0] p);
        return (p == PTR_LAST) ? '0 : p + WPTR'(1);
    endfunction

    logic [WPTR-1:0] wrptr;
    logic [WPTR-1:0] rdptr;
    logic [WPTR-1:0] rdptrm1;
    logic [WPTR-1:0] amt;
    logic [SS-1:0]   sync_q;
    logic            flushs;
    logic            wrinc;
    logic            rdinc;
    logic [W-1:0]    mem [D];

    // ---------------- flush synchronizer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SS-2:0], flushreq};
        end
    end

    assign flushs = sync_q[SS-1];

    // ---------------- handshakes ----------------
    // rdptrm1 trails rdptr by one slot, so wrptr catching it means D-1 words
    // are held; one slot is always sacrificed to tell full from empty.
    assign wrrdy = (wrptr != rdptrm1);
    assign rdvld = (rdptr != wrptr);
    assign wrinc = wrvld & wrrdy;
    assign rdinc = rdvld & rdrdy;
    assign wrnf  = (amt >= NFT_V);

    // ---------------- pointers and occupancy ----------------
    always_ff @(posedge clk) begin
        if (rst || flushs) begin
            wrptr   <= '0;
            rdptr   <= '0;
            rdptrm1 <= PTR_LAST;
            amt     <= '0;
        end else begin
            if (wrinc) begin
                wrptr <= ptr_next(wrptr);
            end
            if (rdinc) begin
                rdptr   <= ptr_next(rdptr);
                rdptrm1 <= rdptr;
            end
            if (wrinc && !rdinc) begin
                amt <= amt + WPTR'(1);
            end else if (rdinc && !wrinc) begin
                amt <= amt + '1;
            end
        end
    end

    // ---------------- storage ----------------
    // Contents are never reset; rddata is meaningless while rdvld is low.
    always_ff @(posedge clk) begin
        if (wrinc) begin
            mem[wrptr] <= wrdata;
        end
    end

    assign rddata = mem[rdptr];

endmodule

// File: tb/tb_powlib_sfifo_sync.sv
// tb/tb_powlib_sfifo_sync.sv - self-checking bench for powlib_sfifo_sync

module tb_powlib_sfifo_sync;

    localparam int SS = 2;

    logic        clk;
    logic        rst;
    logic        flushreq;
    logic [15:0] wrdata [3];
    logic        wrvld  [3];
    logic        wrrdy  [3];
    logic        wrnf   [3];
    logic [15:0] rddata [3];
    logic        rdvld  [3];
    logic        rdrdy  [3];

    int checks = 0;
    int errors = 0;
    int cur    = 0;
    logic [15:0] q [$];

    // instance 0: D=8 NFS=0, instance 1: D=8 NFS=2, instance 2: D=6 NFS=0
    powlib_sfifo_sync #(.W(16), .D(8), .NFS(0), .SS(SS)) u_d8 (
        .clk(clk), .rst(rst), .flushreq(flushreq),
        .wrdata(wrdata[0]), .wrvld(wrvld[0]), .wrrdy(wrrdy[0]), .wrnf(wrnf[0]),
        .rddata(rddata[0]), .rdvld(rdvld[0]), .rdrdy(rdrdy[0]));

    powlib_sfifo_sync #(.W(16), .D(8), .NFS(2), .SS(SS)) u_nf (
        .clk(clk), .rst(rst), .flushreq(flushreq),
        .wrdata(wrdata[1]), .wrvld(wrvld[1]), .wrrdy(wrrdy[1]), .wrnf(wrnf[1]),
        .rddata(rddata[1]), .rdvld(rdvld[1]), .rdrdy(rdrdy[1]));

    powlib_sfifo_sync #(.W(16), .D(6), .NFS(0), .SS(SS)) u_d6 (
        .clk(clk), .rst(rst), .flushreq(flushreq),
        .wrdata(wrdata[2]), .wrvld(wrvld[2]), .wrrdy(wrrdy[2]), .wrnf(wrnf[2]),
        .rddata(rddata[2]), .rdvld(rdvld[2]), .rdrdy(rdrdy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cap_of(input int i);
        return (i == 2) ? 5 : 7;
    endfunction

    function automatic int nft_of(input int i);
        return (i == 1) ? 5 : cap_of(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("wrrdy", 32'(wrrdy[cur]), 32'(q.size() < cap_of(cur)));
        chk("rdvld", 32'(rdvld[cur]), 32'(q.size() > 0));
        chk("wrnf",  32'(wrnf[cur]),  32'(q.size() >= nft_of(cur)));
        if (q.size() > 0) chk("rddata", 32'(rddata[cur]), 32'(q[0]));
    endtask

    // One clock: drive at the falling edge, check against the queue model,
    // then advance the model across the rising edge. clr models a flush edge.
    task automatic step(input logic wv, input logic rr, input logic [15:0] wd, input logic clr);
        bit do_wr;
        bit do_rd;
        wrvld[cur]  = wv;
        rdrdy[cur]  = rr;
        wrdata[cur] = wd;
        #1;
        check_model();
        do_wr = wv && (q.size() < cap_of(cur));
        do_rd = rr && (q.size() > 0);
        @(posedge clk);
        if (clr) begin
            q.delete();
        end else begin
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(wd);
        end
        @(negedge clk);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        flushreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wrvld[i] = 1'b0;
            rdrdy[i] = 1'b0;
            wrdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    typedef struct {
        logic        wv;
        logic        rr;
        logic [15:0] wd;
        logic        e_wrrdy;
        logic        e_rdvld;
        logic        e_wrnf;
        logic [15:0] e_rddata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // fill/drain vectors for D=8 NFS=0; expectations are the outputs
        // visible in the cycle the row's inputs are applied
        for (int i = 0; i < 7; i++)
            tbl[i] = '{1'b1, 1'b0, 16'(16'h10 + i), 1'b1, (i > 0), 1'b0, 16'h0010};
        tbl[7] = '{1'b1, 1'b0, 16'h0017, 1'b0, 1'b1, 1'b1, 16'h0010};
        for (int i = 8; i < 15; i++)
            tbl[i] = '{1'b0, 1'b1, 16'h0000, (i > 8), 1'b1, (i == 8), 16'(16'h10 + i - 8)};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

        flushreq = 1'b0;
        rst_dut();

        // reset state on all instances
        for (int i = 0; i < 3; i++) begin
            chk("reset_wrrdy", 32'(wrrdy[i]), 32'd1);
            chk("reset_rdvld", 32'(rdvld[i]), 32'd0);
            chk("reset_wrnf",  32'(wrnf[i]),  32'd0);
        end

        // first word latency
        cur = 0;
        step(1'b1, 1'b0, 16'h0001, 1'b0);
        chk("latency_rdvld",  32'(rdvld[0]),  32'd1);
        chk("latency_rddata", 32'(rddata[0]), 32'h0001);

        // mid-operation reset
        step(1'b1, 1'b0, 16'h0002, 1'b0);
        rst_dut();
        chk("midrst_rdvld", 32'(rdvld[0]), 32'd0);
        chk("midrst_wrrdy", 32'(wrrdy[0]), 32'd1);

        // table-driven fill and drain
        for (int i = 0; i < 16; i++) begin
            wrvld[0]  = tbl[i].wv;
            rdrdy[0]  = tbl[i].rr;
            wrdata[0] = tbl[i].wd;
            #1;
            chk($sformatf("tbl%0d_wrrdy", i), 32'(wrrdy[0]), 32'(tbl[i].e_wrrdy));
            chk($sformatf("tbl%0d_rdvld", i), 32'(rdvld[0]), 32'(tbl[i].e_rdvld));
            chk($sformatf("tbl%0d_wrnf", i),  32'(wrnf[0]),  32'(tbl[i].e_wrnf));
            if (tbl[i].e_rdvld)
                chk($sformatf("tbl%0d_rddata", i), 32'(rddata[0]), 32'(tbl[i].e_rddata));
            @(posedge clk);
            @(negedge clk);
        end

        // nearly full, NFT=5
        rst_dut();
        cur = 1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h20 + i), 1'b0);
        chk("nf_after4", 32'(wrnf[1]), 32'd0);
        step(1'b1, 1'b0, 16'h0024, 1'b0);
        chk("nf_after5", 32'(wrnf[1]), 32'd1);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("nf_after_read", 32'(wrnf[1]), 32'd0);

        // wrap-around on D=6 with continuous traffic
        rst_dut();
        cur = 2;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 16'(k), 1'b0);
            chk("wrap_rdvld",  32'(rdvld[2]),  32'd1);
            chk("wrap_rddata", 32'(rddata[2]), 32'(k));
            chk("wrap_amt",    32'(u_d6.amt),  32'd1);
        end
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        // simultaneous read and write with 3 words held
        rst_dut();
        cur = 0;
        step(1'b1, 1'b0, 16'h00A0, 1'b0);
        step(1'b1, 1'b0, 16'h00A1, 1'b0);
        step(1'b1, 1'b0, 16'h00A2, 1'b0);
        step(1'b1, 1'b1, 16'h00A3, 1'b0);
        chk("simul_amt",  32'(u_d8.amt),   32'd3);
        chk("simul_head", 32'(rddata[0]),  32'h00A1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);

        // flush with 4 words held; a write on the clearing edge is discarded
        rst_dut();
        cur = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h30 + i), 1'b0);
        flushreq = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        flushreq = 1'b0;
        for (int i = 1; i < SS; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("flush_pending_rdvld", 32'(rdvld[0]), 32'd1);
        step(1'b1, 1'b0, 16'hBEEF, 1'b1);
        chk("flush_rdvld", 32'(rdvld[0]), 32'd0);
        chk("flush_wrrdy", 32'(wrrdy[0]), 32'd1);
        chk("flush_wrnf",  32'(wrnf[0]),  32'd0);
        step(1'b1, 1'b0, 16'hABCD, 1'b0);
        chk("flush_readback", 32'(rddata[0]), 32'hABCD);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        // randomized traffic against the queue model on every instance
        for (int i = 0; i < 3; i++) begin
            rst_dut();
            cur = i;
            for (int n = 0; n < 400; n++) begin
                logic wv;
                logic rr;
                if (n < 200) begin
                    wv = ($urandom_range(0, 3) != 0);
                    rr = ($urandom_range(0, 3) == 0);
                end else begin
                    wv = ($urandom_range(0, 3) == 0);
                    rr = ($urandom_range(0, 3) != 0);
                end
                step(wv, rr, 16'($urandom), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
